// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low pattern table and decode result type.
// Both the encoder and the receiver use this table so the two ends always agree.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index is the nibble value; bit 6 = segment a ... bit 0 = segment g, active-low.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational classifier: 7-bit active-low segment pattern -> {err, blank, nibble}.
// The nibble is forced to 0 for blank and unrecognised patterns.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output seg7_dec_t  dec_o
);

  always_comb begin
    dec_o.err    = 1'b1;
    dec_o.blank  = 1'b0;
    dec_o.nibble = 4'h0;
    if (pattern_i == SEG_BLANK) begin
      dec_o.err   = 1'b0;
      dec_o.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pattern_i == SEG_TABLE[i]) begin
          dec_o.err    = 1'b0;
          dec_o.nibble = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg7_pattern_rx.sv
// Receive side of the multiplexed 7-segment bus: synchronise, debounce, decode and
// present each stable digit pattern once on a valid/ready stream plus a shadow bank.
module seg7_pattern_rx
  import seg7_pkg::*;
#(
  parameter int NDIGITS    = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg_in,
  input  logic [NDIGITS-1:0]     dig_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(NDIGITS)-1:0] out_idx,
  output logic [3:0]             out_data,
  output logic                   out_err,
  output logic                   out_blank,
  output logic                   overflow,
  output logic [4*NDIGITS-1:0]   hex_bank,
  output logic [NDIGITS-1:0]     bank_vld
);

  localparam int IDX_W = $clog2(NDIGITS);
  localparam int CNT_W = $clog2(STABLE_CYC);
  localparam int SW    = NDIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  logic [6:0]         seg_s1_q, seg_s_q;
  logic [NDIGITS-1:0] dig_s1_q, dig_s_q;
  logic [SW-1:0]      samp, samp_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               onehot, emit;
  logic [IDX_W-1:0]   idx_enc;
  seg7_dec_t          dec;

  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;
  logic [3:0]           out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;
  logic                 out_blank_q, out_blank_d;
  logic                 overflow_q, overflow_d;
  logic [4*NDIGITS-1:0] bank_q, bank_d;
  logic [NDIGITS-1:0]   bank_vld_q, bank_vld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s_q  <= '0;
      dig_s1_q <= '0;
      dig_s_q  <= '0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s_q  <= seg_s1_q;
      dig_s1_q <= dig_sel;
      dig_s_q  <= dig_s1_q;
    end
  end

  assign samp   = {dig_s_q, seg_s_q};
  assign onehot = (dig_s_q != '0) && ((dig_s_q & (dig_s_q - 1'b1)) == '0);

  always_comb begin
    idx_enc = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (dig_s_q[i]) idx_enc = IDX_W'(i);
    end
  end

  seg7_pattern_dec u_dec (
    .pattern_i (seg_s_q),
    .dec_o     (dec)
  );

  // Emit fires on the sample that completes a run of STABLE_CYC identical samples;
  // armed stays low until the sample changes, so a held pattern reports once.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    emit    = 1'b0;
    if (samp == samp_prev_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end
    if ((cnt_d == CNT_MAX) && armed_d && onehot) begin
      emit    = 1'b1;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_prev_q <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
    end else begin
      samp_prev_q <= samp;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_blank_d = out_blank_q;
    overflow_d  = overflow_q;
    bank_d      = bank_q;
    bank_vld_d  = bank_vld_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (emit) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_idx_d   = idx_enc;
        out_data_d  = dec.nibble;
        out_err_d   = dec.err;
        out_blank_d = dec.blank;
      end else begin
        overflow_d = 1'b1;
      end
      // The bank tracks every good pattern, even one the stream had to drop.
      if (!dec.err && !dec.blank) begin
        bank_d[int'(idx_enc)*4 +: 4] = dec.nibble;
        bank_vld_d[idx_enc]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_blank_q <= 1'b0;
      overflow_q  <= 1'b0;
      bank_q      <= '0;
      bank_vld_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_blank_q <= out_blank_d;
      overflow_q  <= overflow_d;
      bank_q      <= bank_d;
      bank_vld_q  <= bank_vld_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_blank = out_blank_q;
  assign overflow  = overflow_q;
  assign hex_bank  = bank_q;
  assign bank_vld  = bank_vld_q;

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// Directed bench for seg7_pattern_rx: expected beats are queued as patterns are driven
// and compared by a handshake monitor; bank and timing are checked inline.
module tb_seg7_pattern_rx;

  localparam int ND = 8;
  localparam int SC = 4;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] data;
    logic       err;
    logic       blank;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_idx;
  logic [3:0]    out_data;
  logic          out_err;
  logic          out_blank;
  logic          overflow;
  logic [4*ND-1:0] hex_bank;
  logic [ND-1:0]   bank_vld;

  beat_t         exp_q[$];
  logic [31:0]   bank_m;
  logic [7:0]    vld_m;
  logic [6:0]    tbl[16];
  int            checks = 0;
  int            errors = 0;

  seg7_pattern_rx #(.NDIGITS(ND), .STABLE_CYC(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_blank (out_blank),
    .overflow  (overflow),
    .hex_bank  (hex_bank),
    .bank_vld  (bank_vld)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bank_upd(input int idx, input int data);
    bank_m[idx*4 +: 4] = data[3:0];
    vld_m[idx]         = 1'b1;
  endtask

  task automatic expect_beat(input int idx, input int data, input bit err, input bit blank);
    beat_t b;
    b.idx   = idx[2:0];
    b.data  = data[3:0];
    b.err   = err;
    b.blank = blank;
    exp_q.push_back(b);
    if (!err && !blank) bank_upd(idx, data);
  endtask

  task automatic drive(input logic [7:0] dig, input logic [6:0] seg, input int n);
    dig_sel = dig;
    seg_in  = seg;
    tick(n);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out"}, 64'({out_idx, out_data, out_err, out_blank}), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_bank"}, 64'(hex_bank), 64'd0);
    chk({tag, "_vld"}, 64'(bank_vld), 64'd0);
  endtask

  // Handshake monitor: a beat completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_beat: got idx=%0d data=%0h err=%0b blank=%0b expected none",
               out_idx, out_data, out_err, out_blank);
      end else begin
        beat_t e;
        beat_t g;
        e = exp_q.pop_front();
        g = {out_idx, out_data, out_err, out_blank};
        checks++;
        assert (g === e)
        else begin
          errors++;
          $error("FAIL beat: got idx=%0d data=%0h err=%0b blank=%0b expected idx=%0d data=%0h err=%0b blank=%0b",
                 g.idx, g.data, g.err, g.blank, e.idx, e.data, e.err, e.blank);
        end
      end
    end
  end

  initial begin
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    bank_m    = '0;
    vld_m     = '0;
    rst_n     = 1'b0;
    seg_in    = 7'h7F;
    dig_sel   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(10);
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Digit 3 shows "2": one beat, latency 2 + SC
    out_ready = 1'b1;
    expect_beat(3, 2, 0, 0);
    drive(8'h08, 7'h12, SC + 1);
    chk("lat_early", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'({out_idx, out_data}), 64'({3'd3, 4'h2}));
    tick(10 - (SC + 2));
    chk("d3_bank", 64'(hex_bank[15:12]), 64'h2);
    chk("d3_vld", 64'(bank_vld[3]), 64'd1);

    // Sweep all 16 glyphs over digits 0..7
    for (int d = 0; d < 16; d++) begin
      expect_beat(d % 8, d, 0, 0);
      drive(8'(1 << (d % 8)), tbl[d], 8);
    end
    wait_drain(20);
    chk("sweep_bank", 64'(hex_bank), 64'(bank_m));
    chk("sweep_vld", 64'(bank_vld), 64'(vld_m));
    expect_beat(2, 0, 0, 1);
    drive(8'h04, 7'h7F, 8);
    expect_beat(5, 0, 1, 0);
    drive(8'h20, 7'h55, 8);
    wait_drain(20);
    chk("blank_err_bank", 64'(hex_bank), 64'(bank_m));
    chk("sweep_ovf", 64'(overflow), 64'd0);

    // Glitch shorter than SC between stable runs, then bad digit strobes
    expect_beat(0, 0, 0, 0);
    drive(8'h01, 7'h01, 8);
    drive(8'h01, 7'h4F, SC - 1);
    expect_beat(0, 0, 0, 0);
    drive(8'h01, 7'h01, 8);
    drive(8'h00, 7'h06, 8);
    drive(8'h11, 7'h06, 8);
    wait_drain(20);
    chk("glitch_bank", 64'(hex_bank), 64'(bank_m));
    chk("glitch_vld", 64'(bank_vld), 64'(vld_m));

    // Backpressure: second result is dropped but still banked
    out_ready = 1'b0;
    expect_beat(0, 5, 0, 0);
    drive(8'h01, 7'h24, 8);
    bank_upd(1, 9);
    drive(8'h02, 7'h04, 8);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_held", 64'({out_idx, out_data}), 64'({3'd0, 4'h5}));
    chk("bp_ovf", 64'(overflow), 64'd1);
    chk("bp_bank", 64'(hex_bank), 64'(bank_m));
    chk("bp_vld", 64'(bank_vld), 64'(vld_m));

    // Clear the sticky flag, then emit exactly on an accepting cycle
    drive(8'h00, 7'h7F, 1);
    rst_n = 1'b0;
    exp_q.delete();
    bank_m = '0;
    vld_m  = '0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    expect_beat(2, 4, 0, 0);
    drive(8'h04, 7'h4C, 8);
    chk("acc_hold", 64'(out_valid), 64'd1);
    expect_beat(3, 7, 0, 0);
    drive(8'h08, 7'h0F, SC + 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("acc_valid", 64'(out_valid), 64'd1);
    chk("acc_data", 64'({out_idx, out_data}), 64'({3'd3, 4'h7}));
    chk("acc_ovf", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_drain(10);
    chk("acc_bank", 64'(hex_bank), 64'(bank_m));

    // Reset in the middle of a stability count
    drive(8'h40, 7'h30, 3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    bank_m = '0;
    vld_m  = '0;
    tick(2);
    rst_n = 1'b1;
    expect_beat(6, 14, 0, 0);
    tick(SC + 1);
    chk("rst_lat_early", 64'(out_valid), 64'd0);
    tick();
    chk("rst_lat_valid", 64'(out_valid), 64'd1);
    tick(10);
    wait_drain(10);
    chk("rst_bank", 64'(hex_bank), 64'(bank_m));
    chk("rst_vld", 64'(bank_vld), 64'(vld_m));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
